risc_commit_checker: RTL and testbench
======================================

Name: risc_commit_checker

Overview:
- Synthesizable self-checking monitor for the RISC core.
- Snoops the register-file write port and the flag-update strobe.
- Compares each observed commit, in program order, against an expected-results table loaded before the run.
- Reports per-run pass/fail counts, first-failure capture and a watchdog timeout. Replaces hand-timed register peeks in benches and can sit on-chip for FPGA bring-up.

Parameters:
DATA_W, 32, register/result data width
REG_AW, 4, register address width (16 registers)
FLAG_W, 4, flag vector width, bit order N=0 Z=1 C=2 V=3
NUM_CHECKS, 32, depth of expected-results table
TMO_W, 16, watchdog counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a checking run (pulse)
num_entries  in  $clog2(NUM_CHECKS+1)  entries used this run, sampled on start
timeout_limit  in  TMO_W  max cycles between consumed entries, sampled on start
exp_we  in  1  expected-table write strobe
exp_idx  in  $clog2(NUM_CHECKS)  table index
exp_kind  in  1  0=register check, 1=flags check
exp_addr  in  REG_AW  register number (ignored for flags)
exp_data  in  DATA_W  expected value (low FLAG_W bits for flags)
exp_mask  in  DATA_W  compare mask, 1=bit compared
obs_rf_we  in  1  core register write enable
obs_rf_waddr  in  REG_AW  core write address
obs_rf_wdata  in  DATA_W  core write data
obs_flags_we  in  1  core flag update strobe
obs_flags  in  FLAG_W  new flag value
busy  out  1  run in progress
done  out  1  run finished (level, held)
pass  out  1  done, zero failures, no timeout
timed_out  out  1  run ended by watchdog
pass_count  out  $clog2(NUM_CHECKS+1)  matching entries
fail_count  out  $clog2(NUM_CHECKS+1)  mismatching entries
first_fail_idx  out  $clog2(NUM_CHECKS)  index of first mismatch
first_fail_actual  out  DATA_W  observed value at first mismatch

Behaviour:
- Reset: state IDLE; all outputs 0; table contents are not reset (undefined until written).
- FSM states:
  - IDLE: start → RUN, or → DONE next cycle if num_entries==0 (pass=1).
  - RUN → DONE when the last entry is consumed or the watchdog expires.
  - DONE: holds outputs; start → RUN with counters cleared.
- Table writes are accepted only when busy=0; exp_we in RUN is ignored.
- Start in RUN is ignored. Start clears pass_count, fail_count, first_fail_*, timed_out, done and the entry pointer (ptr=0).
- Matching, one candidate per cycle: the current entry ptr is the only candidate.
  - Register kind: consumed on obs_rf_we && obs_rf_waddr==exp_addr.
  - Flags kind: consumed on obs_flags_we.
  - Non-matching writes (other registers, the other kind) are ignored, not errors.
- Compare: ((observed ^ exp_data) & exp_mask)==0 → pass_count++, else fail_count++.
  - For flags, only the low FLAG_W bits of mask/data are used.
  - first_fail_* is captured only on the first failure of the run.
- Simultaneous register and flag strobes: only the current entry is consumed. If entry ptr+1 is satisfied in the same cycle, that event is lost (the bench must order its table accordingly). At most one entry is consumed per cycle.
- Latency: event in cycle t → counters and ptr updated at edge t+1. done/busy change at the edge after the last consumption (done=1 in cycle t+1 for a last event at t).
- Watchdog:
  - Counter clears on start and on each consumed entry, and increments every RUN cycle otherwise.
  - When counter==timeout_limit-1 with no consumption: → DONE, timed_out=1, pass=0. Unconsumed entries are counted in neither pass nor fail.
  - timeout_limit==0 disables the watchdog.
- Counters saturate at NUM_CHECKS (cannot exceed by construction).
- num_entries > NUM_CHECKS is clamped to NUM_CHECKS.
- Asynchronous reset mid-run: immediate return to IDLE, outputs 0, no completion reported.

Decomposition:
- Package risc_check_pkg:
  - check_kind_e (CHK_REG, CHK_FLAGS).
  - state_e (ST_IDLE, ST_RUN, ST_DONE).
  - Flag bit index constants FLG_N=0, FLG_Z=1, FLG_C=2, FLG_V=3.
- One sub-module: risc_check_watchdog (loadable TMO_W counter with clear, enable and expiry output).
- Table is a flat register array inside the top module.

Test Plan:
- Program-order pass: load 3 entries R1=0x5, R2=0x3, R3=0x8 (mask all-ones); drive those writes with unrelated R0 writes interleaved → done=1, pass=1, pass_count=3, fail_count=0.
- Mismatch capture: entry 1 expects R4=0x3 and the core writes 0x4 → fail_count=1, first_fail_idx=1, first_fail_actual=0x4, pass=0. A later failure leaves first_fail_* unchanged.
- Flags and mask: entry expects flags 0b0010 (Z) with mask 0b0010; obs_flags=0b0110 → pass. A mask of 0xF on the same value → fail.
- Simultaneous strobes: current entry is R8=0 and the next is flags Z; R8 write and flags write occur in the same cycle → entry 0 passes, watchdog later times out with timed_out=1 and pass_count=1.
- Watchdog and restart: timeout_limit=10 with no events → done at cycle 10 after start, timed_out=1. A second start with num_entries=0 → done next cycle, pass=1, counters 0.
- Reset mid-run: assert rst_n low during RUN → busy=0, done=0 and counts 0 asynchronously; exp_we during RUN leaves the table unchanged (verified by a subsequent run).

Source files
------------

// File: rtl/risc_check_pkg.sv
// Shared types and constants for the RISC commit checker: entry kinds,
// checker FSM states and the flag bit positions of the core's flag vector.
package risc_check_pkg;

    typedef enum logic {
        CHK_REG   = 1'b0,
        CHK_FLAGS = 1'b1
    } check_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLG_N = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/risc_check_watchdog.sv
// Inactivity watchdog: loads its limit on run start, restarts on every consumed
// entry and flags expiry on the last allowed idle cycle (limit 0 = disabled).
module risc_check_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [TMO_W-1:0] i_limit,
    input  logic             i_clr,
    input  logic             i_en,
    output logic             o_expired
);

    logic [TMO_W-1:0] r_limit;
    logic [TMO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_limit <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_limit <= i_limit;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    // Expiry fires in the cycle where the count reaches limit-1, so the run
    // ends exactly limit cycles after the last restart.
    assign o_expired = i_en && !i_clr && (r_limit != '0) &&
                       (r_cnt == r_limit - TMO_W'(1));

endmodule

// File: rtl/risc_commit_checker.sv
// Program-order commit checker: snoops register-file writes and flag updates,
// compares each against a preloaded expected-results table and reports results.
module risc_commit_checker
    import risc_check_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 4,
    parameter int FLAG_W     = 4,
    parameter int NUM_CHECKS = 32,
    parameter int TMO_W      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [$clog2(NUM_CHECKS+1)-1:0]   num_entries,
    input  logic [TMO_W-1:0]                  timeout_limit,
    input  logic                              exp_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]     exp_idx,
    input  logic                              exp_kind,
    input  logic [REG_AW-1:0]                 exp_addr,
    input  logic [DATA_W-1:0]                 exp_data,
    input  logic [DATA_W-1:0]                 exp_mask,
    input  logic                              obs_rf_we,
    input  logic [REG_AW-1:0]                 obs_rf_waddr,
    input  logic [DATA_W-1:0]                 obs_rf_wdata,
    input  logic                              obs_flags_we,
    input  logic [FLAG_W-1:0]                 obs_flags,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timed_out,
    output logic [$clog2(NUM_CHECKS+1)-1:0]   pass_count,
    output logic [$clog2(NUM_CHECKS+1)-1:0]   fail_count,
    output logic [$clog2(NUM_CHECKS)-1:0]     first_fail_idx,
    output logic [DATA_W-1:0]                 first_fail_actual
);

    localparam int IW = $clog2(NUM_CHECKS + 1);
    localparam int XW = $clog2(NUM_CHECKS);
    localparam logic [IW-1:0] NUM_MAX = IW'(NUM_CHECKS);

    state_e            r_state;
    state_e            w_state_nxt;

    check_kind_e       r_tbl_kind [NUM_CHECKS];
    logic [REG_AW-1:0] r_tbl_addr [NUM_CHECKS];
    logic [DATA_W-1:0] r_tbl_data [NUM_CHECKS];
    logic [DATA_W-1:0] r_tbl_mask [NUM_CHECKS];

    logic [IW-1:0]     r_num;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     r_pass_cnt;
    logic [IW-1:0]     r_fail_cnt;
    logic [XW-1:0]     r_ff_idx;
    logic [DATA_W-1:0] r_ff_act;
    logic              r_timed_out;

    logic              w_run;
    logic              w_start_ok;
    logic [IW-1:0]     w_num_clamp;
    logic [XW-1:0]     w_cidx;
    logic [DATA_W-1:0] w_obs;
    logic [DATA_W-1:0] w_mask;
    logic              w_hit;
    logic              w_consume;
    logic              w_match;
    logic              w_last;
    logic              w_wd_expired;

    assign w_run       = (r_state == ST_RUN);
    assign w_start_ok  = start && !w_run;
    assign w_num_clamp = (num_entries > NUM_MAX) ? NUM_MAX : num_entries;
    assign w_cidx      = r_ptr[XW-1:0];

    // Table is plain storage: no reset, writes locked out while a run is active.
    always_ff @(posedge clk) begin
        if (exp_we && !w_run && (int'(exp_idx) < NUM_CHECKS)) begin
            r_tbl_kind[exp_idx] <= check_kind_e'(exp_kind);
            r_tbl_addr[exp_idx] <= exp_addr;
            r_tbl_data[exp_idx] <= exp_data;
            r_tbl_mask[exp_idx] <= exp_mask;
        end
    end

    // Only the entry at r_ptr is a candidate; the other strobe kind is ignored.
    always_comb begin
        w_obs  = obs_rf_wdata;
        w_mask = r_tbl_mask[w_cidx];
        w_hit  = obs_rf_we && (obs_rf_waddr == r_tbl_addr[w_cidx]);
        if (r_tbl_kind[w_cidx] == CHK_FLAGS) begin
            w_obs  = DATA_W'(obs_flags);
            w_mask = {{(DATA_W-FLAG_W){1'b0}}, r_tbl_mask[w_cidx][FLAG_W-1:0]};
            w_hit  = obs_flags_we;
        end
    end

    assign w_consume = w_run && w_hit;
    assign w_match   = ((w_obs ^ r_tbl_data[w_cidx]) & w_mask) == '0;
    assign w_last    = w_consume && ((r_ptr + IW'(1)) == r_num);

    risc_check_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_start_ok),
        .i_limit   (timeout_limit),
        .i_clr     (w_consume),
        .i_en      (w_run),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = (w_num_clamp == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_last || w_wd_expired) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num       <= '0;
            r_ptr       <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_act    <= '0;
            r_timed_out <= 1'b0;
        end else if (w_start_ok) begin
            r_num       <= w_num_clamp;
            r_ptr       <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_ff_idx    <= '0;
            r_ff_act    <= '0;
            r_timed_out <= 1'b0;
        end else if (w_consume) begin
            r_ptr <= r_ptr + IW'(1);
            if (w_match) begin
                if (r_pass_cnt != NUM_MAX) r_pass_cnt <= r_pass_cnt + IW'(1);
            end else begin
                if (r_fail_cnt != NUM_MAX) r_fail_cnt <= r_fail_cnt + IW'(1);
                if (r_fail_cnt == '0) begin
                    r_ff_idx <= w_cidx;
                    r_ff_act <= w_obs;
                end
            end
        end else if (w_wd_expired) begin
            r_timed_out <= 1'b1;
        end
    end

    assign busy              = w_run;
    assign done              = (r_state == ST_DONE);
    assign pass              = done && (r_fail_cnt == '0) && !r_timed_out;
    assign timed_out         = r_timed_out;
    assign pass_count        = r_pass_cnt;
    assign fail_count        = r_fail_cnt;
    assign first_fail_idx    = r_ff_idx;
    assign first_fail_actual = r_ff_act;

endmodule

// File: tb/tb_risc_commit_checker.sv
// Directed bench for risc_commit_checker: program-order runs, mismatch capture,
// flag masking, simultaneous strobes, watchdog, restart and asynchronous reset.
module tb_risc_commit_checker;
    import risc_check_pkg::*;

    localparam int DATA_W     = 32;
    localparam int REG_AW     = 4;
    localparam int FLAG_W     = 4;
    localparam int NUM_CHECKS = 32;
    localparam int TMO_W      = 16;
    localparam int IW         = $clog2(NUM_CHECKS + 1);
    localparam int XW         = $clog2(NUM_CHECKS);
    localparam logic [DATA_W-1:0] ALL1 = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [IW-1:0]     num_entries;
    logic [TMO_W-1:0]  timeout_limit;
    logic              exp_we;
    logic [XW-1:0]     exp_idx;
    logic              exp_kind;
    logic [REG_AW-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] exp_mask;
    logic              obs_rf_we;
    logic [REG_AW-1:0] obs_rf_waddr;
    logic [DATA_W-1:0] obs_rf_wdata;
    logic              obs_flags_we;
    logic [FLAG_W-1:0] obs_flags;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timed_out;
    logic [IW-1:0]     pass_count;
    logic [IW-1:0]     fail_count;
    logic [XW-1:0]     first_fail_idx;
    logic [DATA_W-1:0] first_fail_actual;

    int n_cmp = 0;
    int n_err = 0;

    risc_commit_checker #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .FLAG_W(FLAG_W),
        .NUM_CHECKS(NUM_CHECKS), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_entries(num_entries),
        .timeout_limit(timeout_limit), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_kind(exp_kind), .exp_addr(exp_addr), .exp_data(exp_data),
        .exp_mask(exp_mask), .obs_rf_we(obs_rf_we), .obs_rf_waddr(obs_rf_waddr),
        .obs_rf_wdata(obs_rf_wdata), .obs_flags_we(obs_flags_we),
        .obs_flags(obs_flags), .busy(busy), .done(done), .pass(pass),
        .timed_out(timed_out), .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_idx(first_fail_idx), .first_fail_actual(first_fail_actual)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_exp(input int idx, input logic kind, input int addr,
                          input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] mask);
        exp_we   = 1'b1;
        exp_idx  = XW'(idx);
        exp_kind = kind;
        exp_addr = REG_AW'(addr);
        exp_data = data;
        exp_mask = mask;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic do_start(input int n, input int lim);
        start         = 1'b1;
        num_entries   = IW'(n);
        timeout_limit = TMO_W'(lim);
        tick();
        start         = 1'b0;
    endtask

    task automatic rf_write(input int addr, input logic [DATA_W-1:0] data);
        obs_rf_we    = 1'b1;
        obs_rf_waddr = REG_AW'(addr);
        obs_rf_wdata = data;
        tick();
        obs_rf_we    = 1'b0;
    endtask

    task automatic flags_write(input logic [FLAG_W-1:0] f);
        obs_flags_we = 1'b1;
        obs_flags    = f;
        tick();
        obs_flags_we = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (!done && k < max_cyc) begin
            tick();
            k++;
        end
        check(tag, done, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_entries = '0; timeout_limit = '0;
        exp_we = 1'b0; exp_idx = '0; exp_kind = 1'b0; exp_addr = '0;
        exp_data = '0; exp_mask = '0; obs_rf_we = 1'b0; obs_rf_waddr = '0;
        obs_rf_wdata = '0; obs_flags_we = 1'b0; obs_flags = '0;

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_pcnt", pass_count, 0);
        check("rst_fcnt", fail_count, 0);
        check("rst_tmo",  timed_out, 0);
        rst_n = 1'b1;
        tick();

        // Program-order pass with unrelated R0 writes interleaved
        wr_exp(0, CHK_REG, 1, 32'h5, ALL1);
        wr_exp(1, CHK_REG, 2, 32'h3, ALL1);
        wr_exp(2, CHK_REG, 3, 32'h8, ALL1);
        do_start(3, 100);
        check("t1_busy", busy, 1);
        rf_write(0, 32'h99);
        rf_write(1, 32'h5);
        rf_write(0, 32'h1);
        rf_write(2, 32'h3);
        rf_write(0, 32'h7);
        check("t1_notdone", done, 0);
        rf_write(3, 32'h8);
        check("t1_done", done, 1);
        check("t1_busy0", busy, 0);
        check("t1_pass", pass, 1);
        check("t1_pcnt", pass_count, 3);
        check("t1_fcnt", fail_count, 0);

        // Mismatch capture; the second failure must not move first_fail_*
        wr_exp(0, CHK_REG, 5, 32'h11, ALL1);
        wr_exp(1, CHK_REG, 4, 32'h3, ALL1);
        wr_exp(2, CHK_REG, 6, 32'h7, ALL1);
        do_start(3, 100);
        check("t2_cleared_pcnt", pass_count, 0);
        check("t2_cleared_done", done, 0);
        rf_write(5, 32'h11);
        rf_write(4, 32'h4);
        rf_write(6, 32'h9);
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_pcnt", pass_count, 1);
        check("t2_fcnt", fail_count, 2);
        check("t2_ffidx", first_fail_idx, 1);
        check("t2_ffact", first_fail_actual, 32'h4);

        // Flags: only the low FLAG_W bits of mask/data matter
        wr_exp(0, CHK_FLAGS, 0, 32'hA000_0000 | (32'h1 << FLG_Z), 32'hFFFF_FFF0 | (32'h1 << FLG_Z));
        wr_exp(1, CHK_FLAGS, 0, 32'h1 << FLG_Z, 32'hF);
        do_start(2, 100);
        rf_write(2, 32'h123);
        check("t3_ignored_rf", pass_count + fail_count, 0);
        flags_write(4'b0110);
        check("t3_pcnt_mid", pass_count, 1);
        flags_write(4'b0110);
        check("t3_done", done, 1);
        check("t3_pass", pass, 0);
        check("t3_fcnt", fail_count, 1);
        check("t3_ffidx", first_fail_idx, 1);
        check("t3_ffact", first_fail_actual, 32'h6);

        // Simultaneous strobes: the flags event for entry 1 is lost
        wr_exp(0, CHK_REG, 8, 32'h0, ALL1);
        wr_exp(1, CHK_FLAGS, 0, 32'h1 << FLG_Z, 32'h1 << FLG_Z);
        do_start(2, 5);
        obs_rf_we = 1'b1; obs_rf_waddr = 4'd8; obs_rf_wdata = 32'h0;
        obs_flags_we = 1'b1; obs_flags = 4'b0010;
        tick();
        obs_rf_we = 1'b0; obs_flags_we = 1'b0;
        check("t4_pcnt_after", pass_count, 1);
        check("t4_busy", busy, 1);
        wait_done("t4_wait_done", 20);
        check("t4_tmo", timed_out, 1);
        check("t4_pass", pass, 0);
        check("t4_pcnt", pass_count, 1);
        check("t4_fcnt", fail_count, 0);

        // Watchdog exact timing, then restart with zero entries
        do_start(2, 10);
        repeat (9) tick();
        check("t5_done_c9", done, 0);
        tick();
        check("t5_done_c10", done, 1);
        check("t5_tmo", timed_out, 1);
        check("t5_pass", pass, 0);
        check("t5_pcnt", pass_count, 0);
        do_start(0, 10);
        check("t5z_done", done, 1);
        check("t5z_pass", pass, 1);
        check("t5z_tmo", timed_out, 0);
        check("t5z_cnt", pass_count + fail_count, 0);

        // Async reset mid-run; locked-out table write; ignored start
        wr_exp(0, CHK_REG, 1, 32'hAA, ALL1);
        do_start(2, 0);
        rf_write(1, 32'hAA);
        check("t6_pcnt", pass_count, 1);
        wr_exp(0, CHK_REG, 1, 32'hBB, ALL1);
        do_start(0, 0);
        check("t6_start_ignored", busy, 1);
        repeat (30) tick();
        check("t6_wd_disabled", done, 0);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_pcnt", pass_count, 0);
        #2 rst_n = 1'b1;
        tick();
        do_start(0, 0);
        check("t6_zero_done", done, 1);
        check("t6_zero_pass", pass, 1);
        do_start(1, 100);
        rf_write(1, 32'hAA);
        check("t6_done", done, 1);
        check("t6_table_kept", pass, 1);
        check("t6_pcnt2", pass_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
